clk_freq_monitor: RTL and testbench

- Synthesizable checker for a clock produced elsewhere in the design, for example by the testbench clock generator or by a PLL output.
- Samples the monitored clock as a data signal in the `clk` domain. On every rising edge it measures the period and the high time, in `clk` cycles.
- Compares each period against a programmed window, declares lock after a run of good periods, and flags fast, slow or lost clocks.
- Sits beside each generated clock and feeds status to the sim checker and the board health register.

---
 rtl/clk_mon_pkg.sv | 18 +
 rtl/sync_edge_det.sv | 29 ++
 rtl/clk_freq_monitor.sv | 176 +++++++++++++++++
 tb/tb_clk_freq_monitor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock frequency monitor: FSM encodings and
// counter saturation helper.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    function automatic logic [31:0] sat_max(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain for an asynchronous level plus rising-edge detect on
// the synchronized output.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic re
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s  = sync_q[SYNC_STAGES-1];
    assign re = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Measures period and high time of a monitored clock in reference-clock
// cycles, tracks lock against a period window and detects a stopped clock.
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int PER_MIN     = 8,
    parameter int PER_MAX     = 12,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             err_fast,
    output logic             err_slow,
    output logic             lost
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] PMIN    = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0] PMAX    = CNT_W'(PER_MAX);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);

    logic s;
    logic re;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (mon_clk),
        .s  (s),
        .re (re)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [GW-1:0]     good_q, good_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              err_fast_q, err_fast_d;
    logic              err_slow_q, err_slow_d;
    logic              lost_q, lost_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  hcnt_inc;
    logic [GW-1:0]     good_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hcnt_d     = hcnt_q;
        good_d     = good_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        err_fast_d = 1'b0;
        err_slow_d = 1'b0;
        lost_d     = lost_q;

        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
        hcnt_inc = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + ONE;
        good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);

        // Disable overrides every state; measurement results are kept.
        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            good_d   = '0;
            locked_d = 1'b0;
            lost_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if (re) begin
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                        lost_d  = 1'b0;
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    // An edge takes priority over a coincident timeout.
                    if (re) begin
                        cnt_d    = ONE;
                        hcnt_d   = ONE;
                        period_d = cnt_q;
                        high_d   = hcnt_q;
                        valid_d  = 1'b1;
                        if (cnt_q < PMIN) begin
                            err_fast_d = 1'b1;
                            good_d     = '0;
                            locked_d   = 1'b0;
                        end else if (cnt_q > PMAX) begin
                            err_slow_d = 1'b1;
                            good_d     = '0;
                            locked_d   = 1'b0;
                        end else begin
                            good_d   = good_inc;
                            locked_d = (good_inc == GOOD_MAX);
                        end
                    end else if (cnt_q == TMO) begin
                        lost_d   = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        state_d  = ST_ACQ;
                    end else begin
                        cnt_d = cnt_inc;
                        if (s) begin
                            hcnt_d = hcnt_inc;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            good_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_fast_q <= 1'b0;
            err_slow_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            good_q     <= good_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            err_fast_q <= err_fast_d;
            err_slow_q <= err_slow_d;
            lost_q     <= lost_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign err_fast  = err_fast_q;
    assign err_slow  = err_slow_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: table of monitored periods with
// hand-computed results, plus lost-clock, disable and reset sequences.
module tb_clk_freq_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             mon_clk = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             err_fast;
    logic             err_slow;
    logic             lost;

    clk_freq_monitor #(
        .SYNC_STAGES(2),
        .CNT_W      (CNT_W),
        .PER_MIN    (8),
        .PER_MAX    (12),
        .LOCK_CNT   (4),
        .TIMEOUT    (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mon_clk  (mon_clk),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .locked   (locked),
        .err_fast (err_fast),
        .err_slow (err_slow),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    // Monitored clock generator, updated on the falling reference edge.
    // A new period length is taken from per_q at every rising edge.
    int  per_q[$];
    int  cur_per = 10;
    int  last_per = 10;
    int  phase = 0;
    bit  mon_run = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_run) begin
                mon_clk = 1'b0;
                phase   = 0;
            end else begin
                if (phase == 0) begin
                    if (per_q.size() > 0) last_per = per_q.pop_front();
                    cur_per = last_per;
                end
                mon_clk = (phase < cur_per / 2);
                phase   = (phase + 1 == cur_per) ? 0 : phase + 1;
            end
        end
    end

    typedef struct {
        int per;
        int exp_per;
        int exp_high;
        bit exp_lock;
        bit exp_ef;
        bit exp_es;
    } vec_t;

    vec_t tbl[20];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stray = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if ((err_fast || err_slow) && !valid) stray++;
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("valid_seen", got, 1);
    endtask

    task automatic show(input string tag);
        $display("%s: cyc=%0d period=%0d high=%0d locked=%0b ef=%0b es=%0b lost=%0b",
                 tag, cyc, period, high_time, locked, err_fast, err_slow, lost);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int lost_k;
        int lock_before;
        int bad;
        int steps;

        tbl[0]  = '{10, 10, 5, 0, 0, 0};
        tbl[1]  = '{10, 10, 5, 0, 0, 0};
        tbl[2]  = '{10, 10, 5, 0, 0, 0};
        tbl[3]  = '{10, 10, 5, 1, 0, 0};
        tbl[4]  = '{ 6,  6, 3, 0, 1, 0};
        tbl[5]  = '{10, 10, 5, 0, 0, 0};
        tbl[6]  = '{10, 10, 5, 0, 0, 0};
        tbl[7]  = '{10, 10, 5, 0, 0, 0};
        tbl[8]  = '{10, 10, 5, 1, 0, 0};
        tbl[9]  = '{14, 14, 7, 0, 0, 1};
        tbl[10] = '{12, 12, 6, 0, 0, 0};
        tbl[11] = '{ 8,  8, 4, 0, 0, 0};
        tbl[12] = '{12, 12, 6, 0, 0, 0};
        tbl[13] = '{ 8,  8, 4, 1, 0, 0};
        tbl[14] = '{ 7,  7, 3, 0, 1, 0};
        tbl[15] = '{13, 13, 6, 0, 0, 1};
        tbl[16] = '{10, 10, 5, 0, 0, 0};
        tbl[17] = '{10, 10, 5, 0, 0, 0};
        tbl[18] = '{10, 10, 5, 0, 0, 0};
        tbl[19] = '{10, 10, 5, 1, 0, 0};

        // Reset values
        #2;
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_flags", {err_fast, err_slow, lost}, 0);
        step();
        step();
        #2 rst = 1'b0;
        en = 1'b1;
        step();
        step();
        step();

        // Table-driven measurements
        foreach (tbl[i]) per_q.push_back(tbl[i].per);
        mon_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_valid(40, got);
            show($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_period", i), period, tbl[i].exp_per);
            chk($sformatf("vec%0d_high", i), high_time, tbl[i].exp_high);
            chk($sformatf("vec%0d_locked", i), locked, tbl[i].exp_lock);
            chk($sformatf("vec%0d_err_fast", i), err_fast, tbl[i].exp_ef);
            chk($sformatf("vec%0d_err_slow", i), err_slow, tbl[i].exp_es);
        end

        // Lost clock: stop while locked, lost must rise 64 cycles after the valid
        mon_run = 1'b0;
        lost_k = -1;
        lock_before = 0;
        bad = 0;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (valid || err_slow) bad++;
            if (k == 63) lock_before = locked;
            if (lost && lost_k < 0) begin
                lost_k = k;
                break;
            end
        end
        show("lost");
        chk("lost_cycle", lost_k, 64);
        chk("lost_locked_before", lock_before, 1);
        chk("lost_locked", locked, 0);
        chk("lost_no_valid_or_slow", bad, 0);

        // Restart: first edge clears lost with no valid
        mon_run = 1'b1;
        bad = 0;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (valid) bad++;
            if (!lost) begin
                got = 1'b1;
                break;
            end
        end
        show("restart");
        chk("restart_lost_clear", got, 1);
        chk("restart_no_valid", bad, 0);
        wait_valid(40, got);
        show("restart_valid");
        chk("restart_period", period, 10);
        chk("restart_locked", locked, 0);
        for (int k = 0; k < 3; k++) wait_valid(40, got);
        chk("relock", locked, 1);

        // Disable mid-period
        step();
        step();
        step();
        en = 1'b0;
        step();
        show("disable");
        chk("dis_locked", locked, 0);
        chk("dis_lost", lost, 0);
        chk("dis_period_hold", period, 10);
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (valid) bad++;
        end
        chk("dis_no_valid", bad, 0);
        en = 1'b1;
        wait_valid(40, got);
        show("reenable");
        chk("reen_period", period, 10);
        chk("reen_locked", locked, 0);
        for (int k = 0; k < 3; k++) wait_valid(40, got);
        chk("reen_lock", locked, 1);

        // Asynchronous reset between clock edges
        step();
        step();
        #3 rst = 1'b1;
        #1;
        show("async_rst");
        chk("arst_period", period, 0);
        chk("arst_high", high_time, 0);
        chk("arst_locked", locked, 0);
        chk("arst_flags", {valid, err_fast, err_slow, lost}, 0);
        step();
        step();
        #2 rst = 1'b0;
        steps = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            steps++;
            if (valid) begin
                got = 1'b1;
                break;
            end
        end
        show("post_rst");
        chk("prst_valid_seen", got, 1);
        chk("prst_second_edge", steps >= 11, 1);
        chk("prst_period", period, 10);
        chk("prst_locked", locked, 0);

        chk("no_stray_err", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
